// File: rtl/ticks_uart_if.sv
// Report-path signals between the measurement logic and the UART reporter.
interface ticks_uart_if;
  logic        start;
  logic [16:0] ticks;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output start, ticks, input tx, busy, done);
  modport slave  (input start, ticks, output tx, busy, done);
endinterface

// File: rtl/ticks_uart_reporter.sv
// Sends the tick count latched at the falling edge of start as three
// 8N1 UART bytes, MSB byte first, with no idle gap between bytes.
module ticks_uart_reporter #(
  parameter int CLK_F     = 25000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic         clk,
  input  logic         rst,
  ticks_uart_if.slave  bus
);
  localparam int DIV = CLK_F / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_BIT = 2'd1;
  localparam logic [1:0] DATA      = 2'd2;
  localparam logic [1:0] STOP_BIT  = 2'd3;

  logic [1:0]    state;
  logic          start_q;
  logic [16:0]   latch;
  logic [7:0]    shreg;
  logic [1:0]    byte_idx;
  logic [2:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic          tx_q, busy_q, done_q;
  logic          fall;
  logic          bit_end;

  // The button level is registered once; a 1->0 step starts a report.
  assign fall    = start_q & ~bus.start;
  assign bit_end = (cnt == DIV_LAST);

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Framing FSM: each state holds tx for DIV clocks, then moves on at bit_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      latch    <= '0;
      shreg    <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      cnt      <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      start_q <= bus.start;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          // ticks is taken on the detection edge: the last count before the
          // counter clears. Falling edges while busy never reach this state.
          if (fall) begin
            latch    <= bus.ticks;
            shreg    <= {7'b0, bus.ticks[16]};
            byte_idx <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            state    <= START_BIT;
          end
        end
        START_BIT: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_q    <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            cnt <= '0;
            if (byte_idx < 2'd2) begin
              // Next byte's start bit follows the stop bit directly.
              shreg    <= (byte_idx == 2'd0) ? latch[15:8] : latch[7:0];
              byte_idx <= byte_idx + 1'b1;
              tx_q     <= 1'b0;
              state    <= START_BIT;
            end else begin
              tx_q   <= 1'b1;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ticks_uart_reporter.sv
// Directed bench for ticks_uart_reporter at a reduced bit period (DIV=10).
module tb_ticks_uart_reporter;
  localparam int CLK_F = 1000;
  localparam int BAUD  = 100;
  localparam int DIV   = CLK_F / BAUD;
  localparam int FLEN  = 30 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ticks_uart_if bus ();

  ticks_uart_reporter #(.CLK_F(CLK_F), .BAUD_RATE(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic txs [FLEN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one falling edge of start, records the frame, and checks every
  // byte, bit timing, busy length and the done pulse. retrig=1 adds a
  // second start pulse mid-frame plus a ticks change, which must be ignored.
  task automatic run_frame(input string nm, input logic [16:0] v,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input bit retrig);
    logic [7:0] exp_b [3];
    logic [7:0] got;
    int busy_n, done_n, glitch, base;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
    bus.ticks = v;
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    tick();
    busy_n = 0; done_n = 0;
    for (int i = 0; i < FLEN; i++) begin
      txs[i] = bus.tx;
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      if (retrig && i == 60) bus.start = 1'b1;
      if (retrig && i == 80) begin bus.start = 1'b0; bus.ticks = 17'h0abcd; end
      tick();
    end
    chk({nm, "_busy_len"}, busy_n, FLEN);
    chk({nm, "_done_early"}, done_n, 0);
    chk({nm, "_done_pulse"}, {bus.done, bus.busy, bus.tx}, 3'b101);
    glitch = 0;
    for (int b = 0; b < 3; b++) begin
      got = '0;
      for (int p = 0; p < 10; p++) begin
        base = (b * 10 + p) * DIV;
        for (int k = 1; k < DIV; k++) if (txs[base + k] !== txs[base]) glitch++;
        if (p >= 1 && p <= 8) got[p-1] = txs[base + DIV/2];
      end
      chk($sformatf("%s_start%0d", nm, b), txs[b*10*DIV + DIV/2], 1'b0);
      chk($sformatf("%s_stop%0d", nm, b), txs[(b*10+9)*DIV + DIV/2], 1'b1);
      chk($sformatf("%s_byte%0d", nm, b), got, exp_b[b]);
    end
    chk({nm, "_bit_stable"}, glitch, 0);
    tick();
    chk({nm, "_done_clear"}, bus.done, 1'b0);
    if (retrig) begin
      busy_n = 0; done_n = 0;
      for (int i = 0; i < 2 * FLEN; i++) begin
        if (bus.busy) busy_n++;
        if (bus.done) done_n++;
        tick();
      end
      chk({nm, "_no_requeue"}, busy_n + done_n, 0);
    end
  endtask

  initial begin
    int bad;
    bus.start = 1'b0;
    bus.ticks = '0;
    rst = 1'b1;
    tick();
    chk("rst_outputs", {bus.tx, bus.busy, bus.done}, 3'b100);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if ({bus.tx, bus.busy, bus.done} !== 3'b100) bad++;
      tick();
    end
    chk("idle_quiet", bad, 0);

    run_frame("basic", 17'h12345, 8'h01, 8'h23, 8'h45, 1'b0);
    run_frame("max",   17'd96000, 8'h01, 8'h77, 8'h00, 1'b0);
    run_frame("zero",  17'h00000, 8'h00, 8'h00, 8'h00, 1'b0);
    run_frame("retrig", 17'h1a5c3, 8'h01, 8'ha5, 8'hc3, 1'b1);

    // Abort mid-frame.
    bus.ticks = 17'h0ffff;
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    tick();
    chk("abort_started", {bus.tx, bus.busy}, 2'b01);
    repeat (130) tick();
    rst = 1'b1;
    tick();
    chk("abort_outputs", {bus.tx, bus.busy, bus.done}, 3'b100);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < FLEN; i++) begin
      if ({bus.tx, bus.busy, bus.done} !== 3'b100) bad++;
      tick();
    end
    chk("abort_no_done", bad, 0);
    run_frame("after_abort", 17'h0beef, 8'h00, 8'hbe, 8'hef, 1'b0);

    // Reset wins over a simultaneous falling edge.
    bus.start = 1'b1;
    repeat (3) tick();
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_priority", {bus.tx, bus.busy, bus.done}, 3'b100);

    // Reset released with start high: first fall is reported.
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    run_frame("post_rst", 17'h10001, 8'h01, 8'h00, 8'h01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
